// File: rtl/fsm_counter_pkg.sv
// Shared definitions for the fsm_counter demo design: controller state
// encoding and the default counter width used by both the counter and its
// controller.
package fsm_counter_pkg;

  localparam int CNT_W_DEFAULT = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    RUN   = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } ctrl_state_t;

endpackage

// File: rtl/fsm_counter_ctrl.sv
// Initiator for the fsm_counter start/stop interface. Takes a target over a
// valid/ready request channel, pulses start, waits for the counter to equal
// the target, pulses stop and returns the counter value sampled in the stop
// cycle over a valid/ready result channel.
// Optional feature macro: FSM_CTRL_TIMEOUT_EN adds a RUN-state watchdog of
// TIMEOUT_CYC cycles that forces a stop and flags done_err.
module fsm_counter_ctrl
  import fsm_counter_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CNT_W-1:0] req_target,
  output logic             start,
  output logic             stop,
  input  logic [CNT_W-1:0] counter,
  output logic             busy,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [CNT_W-1:0] done_count,
  output logic             done_err
);

  ctrl_state_t      state_reg;
  ctrl_state_t      state_next;
  logic [CNT_W-1:0] target_reg;
  logic [CNT_W-1:0] done_count_reg;
  logic             start_reg;
  logic             stop_reg;
  logic             done_valid_reg;
  logic             done_err_reg;
  logic             accept;
  logic             match;
  logic             timeout;

  // req_ready is only ever high in IDLE, so accepting needs just req_valid there
  assign accept = (state_reg == IDLE) && req_valid;
  // plain equality: a wrap of the counter never produces a false match
  assign match  = (counter == target_reg);

`ifdef FSM_CTRL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] run_cnt_reg;

  // Counts cycles spent in RUN; held at zero in every other state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt_reg <= '0;
    end else if (state_reg == RUN) begin
      run_cnt_reg <= run_cnt_reg + 1'b1;
    end else begin
      run_cnt_reg <= '0;
    end
  end

  // Fires in the last of TIMEOUT_CYC RUN cycles so STOP follows exactly
  // TIMEOUT_CYC edges after RUN entry
  assign timeout = (state_reg == RUN) && (run_cnt_reg == TO_W'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:  if (accept) state_next = (req_target == '0) ? DONE : START;
      START: state_next = RUN;
      RUN:   if (match || timeout) state_next = STOP;
      STOP:  state_next = DONE;
      DONE:  if (done_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake status decoded straight from the current state
  always_comb begin
    req_ready = 1'b0;
    busy      = 1'b1;
    if (state_reg == IDLE) begin
      req_ready = 1'b1;
      busy      = 1'b0;
    end
  end

  // Registered outputs: pulses and done_valid follow the state being entered,
  // so each is high for exactly the cycles spent in its state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_reg      <= 1'b0;
      stop_reg       <= 1'b0;
      done_valid_reg <= 1'b0;
      done_count_reg <= '0;
      done_err_reg   <= 1'b0;
      target_reg     <= '0;
    end else begin
      start_reg      <= (state_next == START);
      stop_reg       <= (state_next == STOP);
      done_valid_reg <= (state_next == DONE);
      if (accept) begin
        target_reg   <= req_target;
        done_err_reg <= 1'b0;
        if (req_target == '0) begin
          done_count_reg <= '0;
        end
      end
      // a match in the timeout cycle wins, so the error is only a bare timeout
      if ((state_reg == RUN) && (state_next == STOP)) begin
        done_err_reg <= timeout && !match;
      end
      if (state_reg == STOP) begin
        done_count_reg <= counter;
      end
    end
  end

  assign start      = start_reg;
  assign stop       = stop_reg;
  assign done_valid = done_valid_reg;
  assign done_count = done_count_reg;
  assign done_err   = done_err_reg;

endmodule

// File: tb/tb_fsm_counter_ctrl.sv
// Self-checking bench for fsm_counter_ctrl. Inputs change and outputs are
// observed at the falling edge; expected results are queued when a request
// is accepted and compared when the result handshake completes.
module tb_fsm_counter_ctrl;

  localparam int CNT_W = 3;

  logic             clk;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [CNT_W-1:0] req_target;
  logic             start;
  logic             stop;
  logic [CNT_W-1:0] counter;
  logic             busy;
  logic             done_valid;
  logic             done_ready;
  logic [CNT_W-1:0] done_count;
  logic             done_err;

  fsm_counter_ctrl #(.CNT_W(CNT_W), .TIMEOUT_CYC(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_target (req_target),
    .start      (start),
    .stop       (stop),
    .counter    (counter),
    .busy       (busy),
    .done_valid (done_valid),
    .done_ready (done_ready),
    .done_count (done_count),
    .done_err   (done_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_n = 0;
  int stop_n = 0;

  logic             acc;
  logic             hs;
  logic [CNT_W:0]   exp_pending;   // {err, count}
  logic [CNT_W:0]   exp_q[$];
  logic [CNT_W-1:0] cnt_q[$];

  // One clock: evaluate the handshakes that the coming rising edge will
  // complete, pass the edge, then apply the next counter value and watch pulses
  task automatic step();
    logic [CNT_W:0] e;
    acc = req_valid && req_ready;
    hs  = done_valid && done_ready;
    if (acc) begin
      exp_q.push_back(exp_pending);
      $display("cyc %0d: request target=%0d", cyc, req_target);
    end
    if (hs) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL result_unexpected: got count=%0d err=%0d, none expected", done_count, done_err);
      end else begin
        e = exp_q.pop_front();
        if ({done_err, done_count} !== e) begin
          errors++;
          $display("FAIL result: got count=%0d err=%0d, expected count=%0d err=%0d",
                   done_count, done_err, e[CNT_W-1:0], e[CNT_W]);
        end else begin
          $display("cyc %0d: result count=%0d err=%0d", cyc, done_count, done_err);
        end
      end
    end
    @(negedge clk);
    cyc++;
    if (cnt_q.size() > 0) counter = cnt_q.pop_front();
    checks++;
    if ((start & stop) !== 1'b0) begin
      errors++;
      $display("FAIL pulse_overlap: start=%b stop=%b, expected not both high", start, stop);
    end
    if (start === 1'b1) start_n++;
    if (stop === 1'b1) stop_n++;
  endtask

  task automatic test_reset();
    int stop_base;
    rst = 1'b1; req_valid = 1'b0; req_target = '0; done_ready = 1'b0; counter = '0;
    step(); step();
    checks++;
    if ({req_ready, busy, start, stop, done_valid, done_err, done_count} !== 9'h100) begin
      errors++;
      $display("FAIL reset_values: got %h, expected 100", {req_ready, busy, start, stop, done_valid, done_err, done_count});
    end
    rst = 1'b0;
    step();
    // start a run toward 5 and reset it while the counter reads 2
    exp_pending = {1'b0, 3'd5};
    req_target = 3'd5; req_valid = 1'b1;
    cnt_q = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 10 && counter != 3'd2; i++) step();
    checks++;
    if (counter !== 3'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_run_reach: counter=%0d busy=%b, expected counter=2 busy=1", counter, busy);
    end
    stop_base = stop_n;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({req_ready, busy, start, stop, done_valid, done_err, done_count} !== 9'h100) begin
      errors++;
      $display("FAIL reset_async: got %h, expected 100", {req_ready, busy, start, stop, done_valid, done_err, done_count});
    end
    exp_q.delete(); cnt_q.delete(); counter = '0;
    step(); step();
    rst = 1'b0;
    step(); step();
    checks++;
    if (stop_n !== stop_base || busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_after_release: stops=%0d busy=%b req_ready=%b, expected stops=%0d busy=0 req_ready=1",
               stop_n, busy, req_ready, stop_base);
    end
  endtask

  task automatic test_zero_target();
    int stn, spn;
    stn = start_n; spn = stop_n;
    exp_pending = {1'b0, 3'd0};
    req_target = 3'd0; req_valid = 1'b1; done_ready = 1'b1;
    step();
    req_valid = 1'b0;
    checks++;
    if (acc !== 1'b1 || done_valid !== 1'b1) begin
      errors++;
      $display("FAIL zero_done_latency: accepted=%b done_valid=%b, expected 1 1", acc, done_valid);
    end
    step(); step();
    checks++;
    if (start_n !== stn || stop_n !== spn) begin
      errors++;
      $display("FAIL zero_no_pulses: starts=%0d stops=%0d, expected %0d %0d", start_n, stop_n, stn, spn);
    end
  endtask

  task automatic test_back_to_back();
    int n_acc, n_hs, rdy_hi, acc2_cyc, hs1_cyc;
    bit in_run;
    n_acc = 0; n_hs = 0; rdy_hi = 0; acc2_cyc = 0; hs1_cyc = 0; in_run = 0;
    done_ready = 1'b1;
    exp_pending = {1'b0, 3'd3};
    req_target = 3'd3; req_valid = 1'b1;
    cnt_q = '{3'd0, 3'd1, 3'd2, 3'd3};
    for (int i = 0; i < 60 && n_hs < 2; i++) begin
      step();
      if (acc) begin
        n_acc++;
        in_run = 1;
        if (n_acc == 1) begin
          req_target = 3'd6; exp_pending = {1'b0, 3'd6};
        end else begin
          req_valid = 1'b0; acc2_cyc = cyc;
        end
      end
      if (hs) begin
        n_hs++;
        in_run = 0;
        if (n_hs == 1) begin
          hs1_cyc = cyc;
          cnt_q = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
        end
      end
      if (in_run && req_ready === 1'b1) rdy_hi++;
    end
    req_valid = 1'b0;
    checks++;
    if (n_hs !== 2 || n_acc !== 2) begin
      errors++;
      $display("FAIL b2b_count: results=%0d accepts=%0d, expected 2 2", n_hs, n_acc);
    end
    checks++;
    if (rdy_hi !== 0) begin
      errors++;
      $display("FAIL b2b_req_ready: high for %0d busy cycles, expected 0", rdy_hi);
    end
    checks++;
    if (acc2_cyc - hs1_cyc !== 1) begin
      errors++;
      $display("FAIL b2b_bubble: second accept %0d cycles after first result, expected 1", acc2_cyc - hs1_cyc);
    end
  endtask

  task automatic test_backpressure();
    done_ready = 1'b0;
    exp_pending = {1'b0, 3'd4};
    req_target = 3'd4; req_valid = 1'b1;
    cnt_q = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 20 && done_valid !== 1'b1; i++) step();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (done_valid !== 1'b1 || done_count !== 3'd4 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d: done_valid=%b done_count=%0d req_ready=%b, expected 1 4 0",
                 i, done_valid, done_count, req_ready);
      end
      step();
    end
    done_ready = 1'b1;
    step();
    checks++;
    if (exp_q.size() !== 0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: pending=%0d req_ready=%b, expected 0 1", exp_q.size(), req_ready);
    end
  endtask

  task automatic test_wrap();
    int c5, stop_cyc, idle_seen;
    bit stop_seen;
    c5 = -1; stop_cyc = -1; idle_seen = 0; stop_seen = 0;
    done_ready = 1'b1;
    exp_pending = {1'b0, 3'd5};
    req_target = 3'd5; req_valid = 1'b1;
    cnt_q = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7,
              3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    step();
    req_valid = 1'b0;
    checks++;
    if (start !== 1'b1) begin
      errors++;
      $display("FAIL start_latency: start=%b one cycle after accept, expected 1", start);
    end
    for (int i = 0; i < 40 && !stop_seen; i++) begin
      step();
      if (busy !== 1'b1) idle_seen++;
      if (stop === 1'b1) begin
        stop_seen = 1; stop_cyc = cyc;
      end else if (counter == 3'd5 && c5 < 0) begin
        c5 = cyc;
      end
    end
    checks++;
    if (!stop_seen || stop_cyc - c5 !== 1 || idle_seen !== 0) begin
      errors++;
      $display("FAIL wrap_stop: stop_seen=%b stop-match=%0d idle_cycles=%0d, expected 1 1 0",
               stop_seen, stop_cyc - c5, idle_seen);
    end
    step();
    checks++;
    if (done_valid !== 1'b1 || stop !== 1'b0) begin
      errors++;
      $display("FAIL done_latency: done_valid=%b stop=%b after stop, expected 1 0", done_valid, stop);
    end
    step(); step();
  endtask

`ifdef FSM_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    int k;
    bit stop_seen;
    stop_seen = 0;
    done_ready = 1'b1;
    counter = 3'd1; cnt_q.delete();
    exp_pending = {1'b1, 3'd1};
    req_target = 3'd3; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    k = cyc;
    for (int i = 0; i < 40 && !stop_seen; i++) begin
      step();
      if (stop === 1'b1) stop_seen = 1;
    end
    checks++;
    if (!stop_seen || cyc - k !== 17) begin
      errors++;
      $display("FAIL timeout_stop: seen=%b at accept+%0d, expected 1 at accept+17", stop_seen, cyc - k);
    end
    step(); step(); step();
  endtask
`endif

  initial begin
    test_reset();
    test_zero_target();
    test_back_to_back();
    test_backpressure();
    test_wrap();
`ifdef FSM_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results outstanding, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
